// File: rtl/regpair_file.sv
// rtl/regpair_file.sv - register-pair file with address latch, two-phase inc/dec unit and pair exchange
// Pairs are {hi, lo}; the IDU adds/subtracts on the address latch low half first, then the high half.
module regpair_file #(
  parameter int HALF_W    = 8,
  parameter int NUM_PAIRS = 6,
  parameter int XCHG_A    = 1,
  parameter int XCHG_B    = 2,
  parameter int SW        = $clog2(NUM_PAIRS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [SW-1:0]         sel_i,
  input  logic [HALF_W-1:0]     dbus_in_i,
  output logic [HALF_W-1:0]     dbus_out_o,
  input  logic                  hi_wr_i,
  input  logic                  lo_wr_i,
  input  logic                  hi_rd_i,
  input  logic                  lo_rd_i,
  input  logic                  pair_to_addr_i,
  output logic [2*HALF_W-1:0]   addr_out_o,
  input  logic                  idu_start_i,
  input  logic                  idu_dec_i,
  input  logic                  idu_step2_i,
  input  logic                  xchg_i,
  output logic                  idu_busy_o,
  output logic                  idu_done_o,
  output logic                  idu_wrap_o
);

  localparam int AW = 2 * HALF_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic [HALF_W-1:0] hi_q [NUM_PAIRS];
  logic [HALF_W-1:0] lo_q [NUM_PAIRS];
  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [HALF_W-1:0] temp_q;
  logic              carry_q;
  logic [SW-1:0]     tgt_q;
  logic              dec_q, step2_q;
  logic              done_q, wrap_q;

  logic              sel_ok, wb, xchg_en, start_ok;
  logic [HALF_W:0]   step_v, lo_calc, hi_calc;

  assign sel_ok   = ({1'b0, sel_i} < (SW+1)'(NUM_PAIRS));
  assign wb       = (state_q == S_HIGH);
  assign start_ok = (state_q == S_IDLE) && idu_start_i && sel_ok;
  // A writeback into either exchanged pair wins; the exchange is dropped entirely.
  assign xchg_en  = xchg_i && !(wb && (tgt_q == SW'(XCHG_A) || tgt_q == SW'(XCHG_B)));

  assign step_v  = step2_q ? (HALF_W+1)'(2) : (HALF_W+1)'(1);
  assign lo_calc = dec_q ? ({1'b0, addr_q[HALF_W-1:0]} - step_v)
                         : ({1'b0, addr_q[HALF_W-1:0]} + step_v);
  assign hi_calc = dec_q ? ({1'b0, addr_q[AW-1:HALF_W]} - (HALF_W+1)'(carry_q))
                         : ({1'b0, addr_q[AW-1:HALF_W]} + (HALF_W+1)'(carry_q));

  always_comb begin
    dbus_out_o = '0;
    if (sel_ok) begin
      if (hi_rd_i)      dbus_out_o = hi_q[sel_i];
      else if (lo_rd_i) dbus_out_o = lo_q[sel_i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_LOW;
      S_LOW:   state_d = S_HIGH;
      S_HIGH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      temp_q  <= '0;
      carry_q <= 1'b0;
      tgt_q   <= '0;
      dec_q   <= 1'b0;
      step2_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= wb;
      // Carry out of the high half is exactly a wrap of the full-width result.
      wrap_q  <= wb & hi_calc[HALF_W];
      if (start_ok) begin
        tgt_q   <= sel_i;
        dec_q   <= idu_dec_i;
        step2_q <= idu_step2_i;
      end
      if (state_q == S_LOW) begin
        temp_q  <= lo_calc[HALF_W-1:0];
        carry_q <= lo_calc[HALF_W];
      end
      if (wb)
        addr_q <= {hi_calc[HALF_W-1:0], temp_q};
      else if ((state_q == S_IDLE) && pair_to_addr_i && sel_ok)
        addr_q <= {hi_q[sel_i], lo_q[sel_i]};
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_PAIRS; i++) begin
      if (rst_i) begin
        hi_q[i] <= '0;
        lo_q[i] <= '0;
      end else if (wb && (tgt_q == SW'(i))) begin
        hi_q[i] <= hi_calc[HALF_W-1:0];
        lo_q[i] <= temp_q;
      end else if (xchg_en && (i == XCHG_A)) begin
        hi_q[i] <= hi_q[XCHG_B];
        lo_q[i] <= lo_q[XCHG_B];
      end else if (xchg_en && (i == XCHG_B)) begin
        hi_q[i] <= hi_q[XCHG_A];
        lo_q[i] <= lo_q[XCHG_A];
      end else if (sel_ok && (sel_i == SW'(i))) begin
        if (hi_wr_i) hi_q[i] <= dbus_in_i;
        if (lo_wr_i) lo_q[i] <= dbus_in_i;
      end
    end
  end

  assign addr_out_o = addr_q;
  assign idu_busy_o = (state_q != S_IDLE);
  assign idu_done_o = done_q;
  assign idu_wrap_o = wrap_q;

endmodule

// File: tb/tb_regpair_file.sv
// tb/tb_regpair_file.sv - scoreboard bench for regpair_file
// Stimulus pushes expectations; a negedge monitor pops them when strobed or when idu_done rises.
module tb_regpair_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [7:0]  dbus_in, dbus_out;
  logic        hi_wr, lo_wr, hi_rd, lo_rd, pair_to_addr;
  logic [15:0] addr_out;
  logic        idu_start, idu_dec, idu_step2, xchg;
  logic        idu_busy, idu_done, idu_wrap;

  always #5 clk = ~clk;

  regpair_file #(.HALF_W(8), .NUM_PAIRS(6), .XCHG_A(1), .XCHG_B(2)) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .dbus_in_i(dbus_in), .dbus_out_o(dbus_out),
    .hi_wr_i(hi_wr), .lo_wr_i(lo_wr), .hi_rd_i(hi_rd), .lo_rd_i(lo_rd),
    .pair_to_addr_i(pair_to_addr), .addr_out_o(addr_out),
    .idu_start_i(idu_start), .idu_dec_i(idu_dec), .idu_step2_i(idu_step2), .xchg_i(xchg),
    .idu_busy_o(idu_busy), .idu_done_o(idu_done), .idu_wrap_o(idu_wrap)
  );

  typedef struct { int kind; int tag; logic [15:0] exp; } chk_t;
  typedef struct { logic [15:0] addr; logic wrap; int tag; } done_t;

  chk_t  chk_q[$];
  done_t done_q[$];
  chk_t  mc;
  done_t md;
  int    chk_n = 0, n_checks = 0, n_fail = 0, tag = 0;
  bit    live = 1'b0;

  task automatic check(input string nm, input int t, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h expected %h", nm, t, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < chk_n; k++) begin
      if (chk_q.size() == 0) begin
        check("chk_queue_underflow", k, 16'h1, 16'h0);
      end else begin
        mc = chk_q.pop_front();
        case (mc.kind)
          0:       check("dbus", mc.tag, {8'h00, dbus_out}, mc.exp);
          1:       check("addr", mc.tag, addr_out, mc.exp);
          default: check("busy", mc.tag, {15'h0, idu_busy}, mc.exp);
        endcase
      end
    end
    if (live) begin
      if (idu_done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 0, 16'h1, 16'h0);
        end else begin
          md = done_q.pop_front();
          check("done_addr", md.tag, addr_out, md.addr);
          check("done_wrap", md.tag, {15'h0, idu_wrap}, {15'h0, md.wrap});
        end
      end else begin
        check("wrap_without_done", 0, {15'h0, idu_wrap}, 16'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    sel = '0; dbus_in = '0; hi_wr = 0; lo_wr = 0; hi_rd = 0; lo_rd = 0;
    pair_to_addr = 0; idu_start = 0; idu_dec = 0; idu_step2 = 0; xchg = 0;
    chk_n = 0;
  endtask

  task automatic push_chk(input int kind, input logic [15:0] e);
    chk_t c;
    c.kind = kind; c.tag = tag; c.exp = e;
    tag++;
    chk_q.push_back(c);
    chk_n++;
  endtask

  task automatic wr(input int s, input bit hi, input logic [7:0] b);
    sel = 3'(s); dbus_in = b;
    if (hi) hi_wr = 1; else lo_wr = 1;
    step();
  endtask

  task automatic wr_pair(input int s, input logic [15:0] v);
    wr(s, 1, v[15:8]);
    wr(s, 0, v[7:0]);
  endtask

  task automatic rd(input int s, input bit hi, input logic [7:0] e);
    sel = 3'(s);
    if (hi) hi_rd = 1; else lo_rd = 1;
    push_chk(0, {8'h00, e});
    step();
  endtask

  task automatic rd_pair(input int s, input logic [15:0] v);
    rd(s, 1, v[15:8]);
    rd(s, 0, v[7:0]);
  endtask

  task automatic to_addr(input int s);
    sel = 3'(s); pair_to_addr = 1;
    step();
  endtask

  task automatic chk_addr(input logic [15:0] e);
    push_chk(1, e);
    step();
  endtask

  // Returns at the start of the done cycle with a busy=0 check pending for it.
  task automatic idu(input int s, input bit dec, input bit s2, input logic [15:0] e, input bit w,
                     input int inj_sel, input logic [7:0] inj_b, input bit inj_start);
    done_t d;
    d.addr = e; d.wrap = w; d.tag = tag;
    tag++;
    done_q.push_back(d);
    sel = 3'(s); idu_start = 1; idu_dec = dec; idu_step2 = s2;
    step();
    push_chk(2, 16'h1);
    if (inj_start) begin sel = 3'(s); idu_start = 1; idu_dec = !dec; end
    step();
    push_chk(2, 16'h1);
    if (inj_sel >= 0) begin sel = 3'(inj_sel); lo_wr = 1; dbus_in = inj_b; end
    step();
    push_chk(2, 16'h0);
  endtask

  initial begin
    rst = 1;
    sel = '0; dbus_in = '0; hi_wr = 0; lo_wr = 0; hi_rd = 0; lo_rd = 0;
    pair_to_addr = 0; idu_start = 0; idu_dec = 0; idu_step2 = 0; xchg = 0;
    step(); step();
    rst = 0;
    live = 1'b1;

    for (int s = 0; s < 6; s++) wr_pair(s, 16'hA55A);
    to_addr(3);
    chk_addr(16'hA55A);
    rd_pair(0, 16'hA55A);
    rst = 1; step(); rst = 0;
    for (int s = 0; s < 6; s++) rd_pair(s, 16'h0000);
    push_chk(2, 16'h0);
    chk_addr(16'h0000);

    wr(6, 1, 8'hEE); wr(7, 0, 8'hEE);
    rd(6, 1, 8'h00); rd(7, 0, 8'h00);
    to_addr(6);
    chk_addr(16'h0000);
    rd_pair(0, 16'h0000);
    sel = 3'd6; idu_start = 1; step();
    push_chk(2, 16'h0); step();

    wr(2, 1, 8'h12); wr(2, 0, 8'h34);
    to_addr(2);
    chk_addr(16'h1234);
    rd(2, 1, 8'h12); rd(2, 0, 8'h34);
    sel = 3'd2; hi_rd = 1; lo_rd = 1; push_chk(0, 16'h0012); step();
    sel = 3'd0; hi_wr = 1; lo_wr = 1; dbus_in = 8'h3C; step();
    rd_pair(0, 16'h3C3C);

    wr_pair(4, 16'h12FF); to_addr(4);
    idu(4, 0, 0, 16'h1300, 0, -1, 8'h00, 0);
    idu(4, 0, 0, 16'h1301, 0, -1, 8'h00, 0);
    rd_pair(4, 16'h1301);
    wr_pair(4, 16'hFFFE); to_addr(4);
    idu(4, 0, 1, 16'h0000, 1, -1, 8'h00, 0);
    rd_pair(4, 16'h0000);
    wr_pair(4, 16'hFFFF); to_addr(4);
    idu(4, 0, 0, 16'h0000, 1, -1, 8'h00, 0);
    wr_pair(4, 16'h0001); to_addr(4);
    idu(4, 1, 1, 16'hFFFF, 1, -1, 8'h00, 0);
    rd_pair(4, 16'hFFFF);

    wr_pair(5, 16'h0000); to_addr(5);
    idu(5, 1, 0, 16'hFFFF, 1, -1, 8'h00, 0);
    rd_pair(5, 16'hFFFF);
    wr_pair(5, 16'h0100); to_addr(5);
    idu(5, 1, 1, 16'h00FE, 0, -1, 8'h00, 0);
    rd_pair(5, 16'h00FE);

    wr_pair(3, 16'h20FF); to_addr(3);
    idu(3, 0, 0, 16'h2100, 0, 3, 8'h77, 1);
    rd_pair(3, 16'h2100);
    wr_pair(3, 16'h20FF); to_addr(3);
    idu(3, 0, 0, 16'h2100, 0, 0, 8'h77, 1);
    rd_pair(0, 16'h3C77);
    rd_pair(3, 16'h2100);

    wr_pair(1, 16'h1111); wr_pair(2, 16'h2222);
    xchg = 1; step();
    rd_pair(1, 16'h2222); rd_pair(2, 16'h1111);
    xchg = 1; sel = 3'd1; hi_wr = 1; dbus_in = 8'h99; step();
    rd_pair(1, 16'h1111); rd_pair(2, 16'h2222);

    wr_pair(5, 16'hABCD); to_addr(5);
    sel = 3'd5; idu_start = 1; step();
    rst = 1; step(); rst = 0;
    push_chk(2, 16'h0);
    chk_addr(16'h0000);
    for (int s = 0; s < 6; s++) rd_pair(s, 16'h0000);
    repeat (5) step();

    check("done_queue_drained", 0, 16'(done_q.size()), 16'h0);
    check("chk_queue_drained", 0, 16'(chk_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regpair_file.md
# regpair_file

Parametrised register-pair file with an integrated two-phase increment/decrement unit (IDU) and address latch, the generalised successor to the fixed BC/DE/HL/WZ/PC/SP register file of the 8085 core. It holds NUM_PAIRS pairs of two HALF_W-bit halves, exchanges bytes with the internal data bus, loads the address latch that drives the external address bus, and performs carry-chained ±1/±2 arithmetic on the latch with writeback to a pair. It also supports a single-cycle pair exchange (XCHG).

## Interface
- HALF_W, 8, width of one register half; pair and address width is 2*HALF_W
- NUM_PAIRS, 6, number of register pairs (index 0..NUM_PAIRS-1)
- XCHG_A, 1, first pair index swapped by xchg
- XCHG_B, 2, second pair index swapped by xchg
- SW, $clog2(NUM_PAIRS), width of pair-select inputs
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- sel  in  SW  pair addressed by bus reads/writes, pair_to_addr and idu_start
- dbus_in  in  HALF_W  data bus byte to write
- dbus_out  out  HALF_W  data bus byte read (combinational from registers)
- hi_wr / lo_wr  in  1  write dbus_in into high / low half of pair sel
- hi_rd / lo_rd  in  1  drive high / low half of pair sel onto dbus_out
- pair_to_addr  in  1  load address latch from pair sel
- addr_out  out  2*HALF_W  address latch contents
- idu_start  in  1  start IDU operation on address latch
- idu_dec  in  1  with idu_start: 1 = decrement, 0 = increment
- idu_step2  in  1  with idu_start: step 2 instead of 1
- xchg  in  1  swap pairs XCHG_A and XCHG_B
- idu_busy  out  1  IDU operation in progress
- idu_done  out  1  one-cycle pulse after writeback
- idu_wrap  out  1  valid with idu_done: result wrapped through 0

## Operation
- Storage: pair[i] = {hi, lo}; addr latch 2*HALF_W bits; IDU FSM with states IDLE, LOW, HIGH; temp low-half register and carry bit; latched target index, dec and step.
- dbus_out: hi_rd → pair[sel].hi; else lo_rd → pair[sel].lo; else 0. hi_rd has priority.
- hi_wr/lo_wr both set: both halves written with dbus_in.
- pair_to_addr: addr latch ← pair[sel] at the edge.
- IDU IDLE: idu_start samples sel, idu_dec and idu_step2, then goes to LOW. idu_start in LOW/HIGH is ignored.
- LOW: temp ← addr.lo ± step (HALF_W bits); carry/borrow ← carry out of the low half. Next state HIGH.
- HIGH: result.hi = addr.hi ± carry/borrow. At the edge, pair[target] ← {hi, temp} and addr ← {hi, temp}. Set idu_done. Set idu_wrap if the full 2*HALF_W result overflowed or underflowed. Next state IDLE.
- Arithmetic is modulo 2^(2*HALF_W): FFFF+1=0000, FFFF+2=0001, 0000−1=FFFF, 0001−2=FFFF (all wrap=1).
- Priority on the same pair in the HIGH-edge: IDU writeback beats hi_wr/lo_wr, which are dropped for that pair only. Writes to other pairs proceed normally.
- pair_to_addr during LOW/HIGH is ignored; the latch is owned by the IDU.
- xchg: pair[XCHG_A] and pair[XCHG_B] are swapped atomically at the edge. xchg beats hi_wr/lo_wr targeting either pair. If the IDU writeback targets XCHG_A or XCHG_B in the same edge, xchg is ignored.
- Out-of-range sel (≥ NUM_PAIRS): reads return 0; writes, pair_to_addr and idu_start are ignored.

## Timing
- Reset: all pairs = 0, addr_out = 0, FSM IDLE, idu_busy = 0, idu_done = 0, idu_wrap = 0, temp/carry = 0.
- Reset mid-operation aborts the IDU with no writeback.
- Bus write visible on dbus_out the cycle after its edge. Read is zero-latency.
- idu_start sampled at edge E0. idu_busy = 1 from E0 to E2. Writeback at E2. addr_out and pair show the result, and idu_done/idu_wrap are high, for exactly the cycle after E2.
- Back-to-back: idu_start asserted during the done cycle is accepted at that edge. Throughput is one operation per 3 cycles.
- idu_wrap clears with idu_done.

## Test plan
- Reset: pair 0..5 written 0xA5/0x5A, assert rst one cycle → all reads 0x00, addr_out 0x0000, idu_busy 0.
- Write/read: sel=2, hi_wr with 0x12, then lo_wr with 0x34; pair_to_addr → addr_out 0x1234; hi_rd gives 0x12, lo_rd gives 0x34 on dbus_out.
- Increment with carry: PC (sel 4) = 0x12FF, pair_to_addr, idu_start inc step1 → busy for 2 cycles, then pair4 = addr_out = 0x1300, done=1, wrap=0. Repeat from 0xFFFE with step2 → 0x0000, wrap=1.
- Decrement: SP (sel 5) = 0x0000, dec step1 → 0xFFFF, wrap=1. Then 0x0100 with step2 → 0x00FE, wrap=0.
- Conflicts: during the HIGH cycle, lo_wr 0x77 to the target pair → writeback value kept. The same lo_wr to another pair → 0x77 stored. idu_start while busy → ignored, single done pulse.
- xchg: pair1 = 0x1111, pair2 = 0x2222, pulse xchg → pair1 = 0x2222, pair2 = 0x1111. Then assert rst during LOW → no writeback, all state 0.
